// File: rtl/spi_mailbox_master.sv
// SPI drain engine for the mailbox RAM: polls slots round-robin, sends each entry as a 40-bit mode-0 frame and writes back.
// Optional read-complete irq output when SPIMB_IRQ_EN is defined.
module spi_mailbox_master #(
  parameter int unsigned SLOTS   = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mb_en,
  output logic [4:0]  mb_addr,
  input  logic [40:0] mb_rdata,
  input  logic        mb_valid,
  output logic        mb_done,
  output logic [40:0] mb_wdata,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
`ifdef SPIMB_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, POLL, LOAD, SHIFT, TAIL, GAP, RETIRE
  } state_t;

  state_t state_q, state_d;

  logic             poll_ph;
  logic [4:0]       addr_q;
  logic [4:0]       next_addr;
  logic [40:0]      entry_q;
  logic [38:0]      shreg_q;
  logic [39:0]      frame;
  logic [31:0]      rx_q;
  logic [DIV_W-1:0] div_q;
  logic [5:0]       bit_q;
  logic             cs_n_q, sclk_q, mosi_q;

  assign next_addr = (addr_q == 5'(SLOTS - 1)) ? '0 : addr_q + 5'd1;
  // Read frames carry only the command byte; the data phase is clocked out as zeros.
  assign frame = {entry_q[40], entry_q[38:32], entry_q[40] ? 32'h0 : entry_q[31:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = POLL;
      POLL:    if (poll_ph && mb_valid) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (div_q == LAST && bit_q == 6'd39) state_d = TAIL;
      TAIL:    if (div_q == HALF) state_d = GAP;
      GAP:     if (div_q == LAST) state_d = RETIRE;
      RETIRE:  state_d = POLL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_ph <= 1'b0;
      addr_q  <= '0;
      entry_q <= '0;
      shreg_q <= '0;
      rx_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      unique case (state_q)
        POLL: begin
          // RAM read latency: address held one cycle, valid sampled on the second.
          poll_ph <= ~poll_ph;
          if (poll_ph) begin
            if (mb_valid) entry_q <= mb_rdata;
            else          addr_q  <= next_addr;
          end
        end
        LOAD: begin
          shreg_q <= frame[38:0];
          mosi_q  <= frame[39];
          cs_n_q  <= 1'b0;
          div_q   <= '0;
          bit_q   <= '0;
          rx_q    <= '0;
        end
        SHIFT: begin
          if (div_q == LAST) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            if (bit_q == 6'd39) begin
              mosi_q <= 1'b0;
            end else begin
              bit_q   <= bit_q + 6'd1;
              mosi_q  <= shreg_q[38];
              shreg_q <= {shreg_q[37:0], 1'b0};
            end
          end else begin
            div_q <= div_q + 1'b1;
            if (div_q == HALF) begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[30:0], spi_miso};
            end
          end
        end
        TAIL: begin
          if (div_q == HALF) begin
            div_q  <= '0;
            cs_n_q <= 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        GAP:     div_q <= (div_q == LAST) ? '0 : div_q + 1'b1;
        RETIRE: begin
          addr_q  <= next_addr;
          poll_ph <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mb_en    = 1'b0;
    mb_done  = 1'b0;
    mb_wdata = '0;
    unique case (state_q)
      POLL:    mb_en = 1'b1;
      RETIRE: begin
        mb_en    = 1'b1;
        mb_done  = 1'b1;
        mb_wdata = entry_q[40] ? {1'b1, entry_q[39:32], rx_q} : entry_q;
      end
      default: ;
    endcase
  end

  assign mb_addr  = addr_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

`ifdef SPIMB_IRQ_EN
  assign irq = (state_q == RETIRE) && entry_q[40];
`endif

endmodule

// File: tb/tb_spi_mailbox_master.sv
// Scoreboard bench for spi_mailbox_master: two instances (CLK_DIV 4 and 2), each with a mailbox RAM model,
// an SPI slave register-file model and a monitor that checks frames, timing and write-backs.
module tb_spi_mailbox_master;

  int tests = 0;
  int fails = 0;
  bit fin [2];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] regs [128];

  typedef struct {
    int          slot;
    logic [40:0] wdata;
    logic [39:0] frame;
    bit          rd;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = $urandom;
    regs[7'h12] = 32'hCAFEF00D;
  end

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int unsigned C = (g == 0) ? 4 : 2;

    logic        rst_n;
    logic        mb_en;
    logic [4:0]  mb_addr;
    logic [40:0] mb_rdata;
    logic        mb_valid;
    logic        mb_done;
    logic [40:0] mb_wdata;
    logic        spi_cs_n, spi_sclk, spi_mosi, spi_miso;
`ifdef SPIMB_IRQ_EN
    logic        irq;
`endif

    spi_mailbox_master #(.SLOTS(16), .CLK_DIV(C)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mb_en    (mb_en),
      .mb_addr  (mb_addr),
      .mb_rdata (mb_rdata),
      .mb_valid (mb_valid),
      .mb_done  (mb_done),
      .mb_wdata (mb_wdata),
      .spi_cs_n (spi_cs_n),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso)
`ifdef SPIMB_IRQ_EN
      ,
      .irq      (irq)
`endif
    );

    logic [40:0] mem [16];
    bit          pend [16];
    exp_t        sb [$];

    int          cyc, last_en, cs_fall, last_rise, last_fall, cs_rise, nrise, nfall, bad_per;
    int          next_exp, ptr, last, cnt, n, prev_a, chg, last_chg, bad, rs;
    bit          chk_next;
    logic        prev_cs, prev_sclk;
    logic [39:0] frame_cap;
    logic [7:0]  cmd;
    logic [31:0] resp;
    exp_t        e;

    function automatic logic [40:0] rand_ent();
      return {1'($urandom), 8'($urandom), 32'($urandom)};
    endfunction

    task automatic post(input int s, input logic [40:0] ent);
      exp_t x;
      mem[s]  = ent;
      pend[s] = 1'b1;
      x.slot  = s;
      x.rd    = ent[40];
      x.frame = {ent[40], ent[38:32], ent[40] ? 32'h0 : ent[31:0]};
      x.wdata = ent[40] ? {1'b1, ent[39:32], regs[ent[38:32]]} : ent;
      sb.push_back(x);
    endtask

    task automatic drain(input int limit);
      int k = 0;
      while (sb.size() != 0 && k < limit) begin
        @(posedge clk);
        k++;
      end
      #2;
      chk($sformatf("h%0d drain_in_time", g), 64'(k < limit), 64'd1);
      if (k >= limit) sb.delete();
    endtask

    // Mailbox RAM, SPI slave and monitor, all evaluated on the falling clock edge.
    initial begin : model
      mb_rdata = '0; mb_valid = 1'b0; spi_miso = 1'b0;
      cyc = 0; last_en = 0; cs_fall = 0; last_rise = 0; last_fall = 0; cs_rise = 0;
      nrise = 0; nfall = 0; bad_per = 0; chk_next = 0; next_exp = 0;
      prev_cs = 1'b1; prev_sclk = 1'b0; frame_cap = '0; cmd = '0; resp = '0;
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
          prev_cs = 1'b1; prev_sclk = 1'b0; nrise = 0; nfall = 0; chk_next = 0; spi_miso = 1'b0;
        end else begin
          if (chk_next) begin
            chk($sformatf("h%0d next_poll_addr", g), 64'(mb_addr), 64'(next_exp));
            chk_next = 0;
          end
          if (mb_en && !mb_done) last_en = cyc;
          if (prev_cs && !spi_cs_n) begin
            if (cs_rise > 0) chk($sformatf("h%0d cs_high_between_frames_ge8", g), 64'((cyc - cs_rise) >= 8), 64'd1);
            chk($sformatf("h%0d valid_to_cs_fall", g), 64'(cyc - last_en), 64'd2);
            cs_fall = cyc; nrise = 0; nfall = 0; bad_per = 0; frame_cap = '0;
            spi_miso = 1'($urandom);
          end
          if (!spi_cs_n && !prev_sclk && spi_sclk) begin
            nrise++;
            frame_cap = {frame_cap[38:0], spi_mosi};
            if (nrise == 1) chk($sformatf("h%0d first_rise", g), 64'(cyc - cs_fall), 64'(C));
            else if (cyc - last_rise != 2 * C) bad_per++;
            last_rise = cyc;
          end
          if (!spi_cs_n && prev_sclk && !spi_sclk) begin
            nfall++;
            last_fall = cyc;
            if (nfall == 8) begin
              cmd  = frame_cap[7:0];
              resp = cmd[7] ? regs[cmd[6:0]] : $urandom;
            end
            spi_miso = (nfall >= 8 && nfall <= 39) ? resp[39 - nfall] : 1'($urandom);
          end
          if (!prev_cs && spi_cs_n) begin
            cs_rise = cyc;
            chk($sformatf("h%0d tail_len", g), 64'(cyc - last_fall), 64'(C));
          end
          if (mb_done) begin
            if (sb.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL h%0d unexpected_done: slot %0d retired, expected no retire", g, mb_addr);
            end else begin
              e = sb.pop_front();
              chk($sformatf("h%0d done_slot", g), 64'(mb_addr), 64'(e.slot));
              chk($sformatf("h%0d wdata", g), 64'(mb_wdata), 64'(e.wdata));
              chk($sformatf("h%0d mosi_frame", g), 64'(frame_cap), 64'(e.frame));
              chk($sformatf("h%0d sclk_rises", g), 64'(nrise), 64'd40);
              chk($sformatf("h%0d sclk_period_errors", g), 64'(bad_per), 64'd0);
              chk($sformatf("h%0d frame_len", g), 64'(last_fall - cs_fall), 64'(80 * C));
              chk($sformatf("h%0d gap_len", g), 64'(cyc - cs_rise), 64'(2 * C));
              chk($sformatf("h%0d valid_to_done", g), 64'(cyc - last_en), 64'(83 * C + 2));
`ifdef SPIMB_IRQ_EN
              chk($sformatf("h%0d irq", g), 64'(irq), 64'(e.rd));
`endif
              chk_next = 1;
              next_exp = (e.slot + 1) % 16;
            end
            mem[mb_addr]  = mb_wdata;
            pend[mb_addr] = 1'b0;
          end
`ifdef SPIMB_IRQ_EN
          else chk($sformatf("h%0d irq_idle", g), 64'(irq), 64'd0);
`endif
          prev_cs   = spi_cs_n;
          prev_sclk = spi_sclk;
        end
        if (mb_en) begin
          mb_rdata = mem[mb_addr];
          mb_valid = pend[mb_addr];
        end
      end
    end

    initial begin : stim
      rst_n = 1'b0;
      for (int i = 0; i < 16; i++) begin mem[i] = '0; pend[i] = 1'b0; end
      repeat (3) @(posedge clk);
      #2;
      chk($sformatf("h%0d rst_cs_n", g), 64'(spi_cs_n), 64'd1);
      chk($sformatf("h%0d rst_sclk", g), 64'(spi_sclk), 64'd0);
      chk($sformatf("h%0d rst_addr", g), 64'(mb_addr), 64'd0);
      chk($sformatf("h%0d rst_en_done", g), 64'({mb_en, mb_done, spi_mosi}), 64'd0);
      chk($sformatf("h%0d rst_wdata", g), 64'(mb_wdata), 64'd0);
      rst_n = 1'b1;

      prev_a = int'(mb_addr); chg = 0; last_chg = 0; bad = 0;
      for (int c = 1; c <= 100; c++) begin
        @(posedge clk);
        #2;
        if (spi_cs_n !== 1'b1 || mb_done !== 1'b0) bad++;
        if (int'(mb_addr) != prev_a) begin
          chg++;
          chk($sformatf("h%0d empty_addr_step", g), 64'(mb_addr), 64'((prev_a + 1) % 16));
          if (chg > 1) chk($sformatf("h%0d empty_poll_period", g), 64'(c - last_chg), 64'd2);
          last_chg = c;
          prev_a   = int'(mb_addr);
        end
      end
      chk($sformatf("h%0d empty_bus_quiet", g), 64'(bad), 64'd0);

      post(3, 41'h0A5DEADBEEF);
      drain(2000);
      ptr = 4;
      post(15, {1'b1, 8'h12, 32'($urandom)});
      drain(2000);
      ptr = 0;
      post(2, {1'b0, 8'($urandom), 32'($urandom)});
      post(5, {1'b1, 8'($urandom), 32'($urandom)});
      drain(4000);
      ptr = 6;

      rs = int'($urandom_range(15));
      post(rs, rand_ent());
      n = 0;
      while (spi_cs_n && n < 2000) begin
        @(posedge clk);
        #2;
        n++;
      end
      chk($sformatf("h%0d frame_start_in_time", g), 64'(n < 2000), 64'd1);
      repeat (41 * C) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk($sformatf("h%0d midframe_rst_cs_n", g), 64'(spi_cs_n), 64'd1);
      chk($sformatf("h%0d midframe_rst_sclk", g), 64'(spi_sclk), 64'd0);
      chk($sformatf("h%0d midframe_rst_outs", g), 64'({mb_done, mb_en, spi_mosi, mb_addr}), 64'd0);
      chk($sformatf("h%0d midframe_not_retired", g), 64'(sb.size()), 64'd1);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      drain(2000);
      ptr = (rs + 1) % 16;

      for (int b = 0; b < 5; b++) begin
        cnt = 0;
        for (int d = 0; d < 16; d++) begin
          if ($urandom_range(3) == 0) begin
            post((ptr + d) % 16, rand_ent());
            last = (ptr + d) % 16;
            cnt++;
          end
        end
        if (cnt == 0) begin
          post(ptr, rand_ent());
          last = ptr;
          cnt  = 1;
        end
        drain(cnt * (90 * C + 40) + 200);
        ptr = (last + 1) % 16;
      end
      fin[g] = 1'b1;
    end
  end

  initial begin
    wait (fin[0] && fin[1]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
